// File: rtl/sr_pkg.sv
// Shared SR command encodings and scheduler state type.
// Op codes match the cmd_op port bit-for-bit.
package sr_pkg;

   typedef logic [1:0] sr_op_t;

   localparam sr_op_t SR_OP_HOLD = 2'b00;
   localparam sr_op_t SR_OP_CLR  = 2'b01;
   localparam sr_op_t SR_OP_SET  = 2'b10;
   localparam sr_op_t SR_OP_TGL  = 2'b11;

   typedef enum logic [1:0] {
      SR_ST_IDLE  = 2'd0,
      SR_ST_ISSUE = 2'd1,
      SR_ST_CHECK = 2'd2,
      SR_ST_GAP   = 2'd3
   } sr_sched_state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small synchronous FIFO, head visible combinationally on pop_data; level updates one edge after push/pop.
// Push ignored when full, pop ignored when empty; simultaneous push+pop leaves level unchanged.
module sr_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sr_cmd_scheduler.sv
// Buffers set/clear/toggle/hold ops and issues each as a single registered s or r pulse, then checks q_fb.
// Pulse two edges after accept, one op per 3+GAP cycles; cmd_ready low while full or in reset.
module sr_cmd_scheduler
   import sr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP   = 1,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic [1:0]    cmd_op,
   output logic          cmd_ready,
   input  logic          q_fb,
   output logic          s,
   output logic          r,
   output logic          busy,
   output logic [LW-1:0] level,
   output logic          mismatch
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   sr_sched_state_t state;
   sr_op_t          head_op;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            expected;
   logic [GW-1:0]   gap_cnt;
   logic            set_nxt;
   logic            clr_nxt;
   logic            exp_nxt;

   // Readiness uses the pre-pop level: a pop from a full FIFO frees no slot this cycle.
   assign cmd_ready = !rst && !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == SR_ST_IDLE) && !fifo_empty;
   assign busy      = (state != SR_ST_IDLE) || !fifo_empty;

   sr_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2),
      .LW    (LW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (cmd_op),
      .pop       (pop),
      .pop_data  (head_op),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_comb begin
      set_nxt = 1'b0;
      clr_nxt = 1'b0;
      exp_nxt = q_fb;
      case (head_op)
         SR_OP_SET: begin
            set_nxt = 1'b1;
            exp_nxt = 1'b1;
         end
         SR_OP_CLR: begin
            clr_nxt = 1'b1;
            exp_nxt = 1'b0;
         end
         SR_OP_TGL: begin
            set_nxt = !q_fb;
            clr_nxt = q_fb;
            exp_nxt = !q_fb;
         end
         default: ;
      endcase
   end

   // s/r default low every cycle and are only loaded on the IDLE->ISSUE step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SR_ST_IDLE;
         s        <= 1'b0;
         r        <= 1'b0;
         mismatch <= 1'b0;
         expected <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         s        <= 1'b0;
         r        <= 1'b0;
         mismatch <= 1'b0;
         case (state)
            SR_ST_IDLE: begin
               if (!fifo_empty) begin
                  s        <= set_nxt;
                  r        <= clr_nxt;
                  expected <= exp_nxt;
                  state    <= SR_ST_ISSUE;
               end
            end
            SR_ST_ISSUE: state <= SR_ST_CHECK;
            SR_ST_CHECK: begin
               mismatch <= (q_fb != expected);
               gap_cnt  <= '0;
               state    <= (GAP > 0) ? SR_ST_GAP : SR_ST_IDLE;
            end
            SR_ST_GAP: begin
               if (gap_cnt == GW'(GAP - 1)) state <= SR_ST_IDLE;
               else                         gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= SR_ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_scheduler.sv
// Bench: scheduler driving a one-edge SR flip-flop, with a queue/timeline reference model
// checked every cycle plus directed literal expectations.
module tb_sr_cmd_scheduler;
   import sr_pkg::*;

   localparam int DEPTH_P = 4;
   localparam int GAP_P   = 1;
   localparam int LW_P    = $clog2(DEPTH_P + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd_op = 2'b00;
   logic            cmd_ready;
   logic            q_fb;
   logic            s;
   logic            r;
   logic            busy;
   logic [LW_P-1:0] level;
   logic            mismatch;

   logic q = 1'b0;
   logic force_low = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   int         pcyc[$];
   logic [1:0] pcode[$];
   int         mm_cnt = 0;
   int         max_level = 0;

   always #5 clk = ~clk;

   sr_cmd_scheduler #(.DEPTH(DEPTH_P), .GAP(GAP_P), .LW(LW_P)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .q_fb      (q_fb),
      .s         (s),
      .r         (r),
      .busy      (busy),
      .level     (level),
      .mismatch  (mismatch)
   );

   // Plain one-edge SR flip-flop under control of the scheduler.
   always @(posedge clk) begin
      if (s)      q <= 1'b1;
      else if (r) q <= 1'b0;
   end
   assign q_fb = force_low ? 1'b0 : q;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a queue of accepted ops and a timeline of when each popped op pulses,
   // is checked and frees the scheduler again.
   sr_op_t mq[$];
   int     free_cyc = 0;
   int     pulse_cyc = -1;
   int     check_cyc = -1;
   int     mm_cyc = -1;
   logic   pulse_s = 1'b0;
   logic   pulse_r = 1'b0;
   logic   check_exp = 1'b0;
   logic   mm_val = 1'b0;
   logic   model_q = 1'b0;
   logic   armed = 1'b0;

   always @(negedge clk) begin
      int     sz;
      logic   e_s, e_r, e_mm, e_rdy, e_busy;
      sr_op_t op;
      sz     = mq.size();
      e_s    = (cyc == pulse_cyc) && pulse_s;
      e_r    = (cyc == pulse_cyc) && pulse_r;
      e_mm   = (cyc == mm_cyc) && mm_val;
      e_rdy  = !rst && (sz != DEPTH_P);
      e_busy = (cyc < free_cyc) || (sz != 0);
      if (armed) begin
         chk("s", 32'(s), 32'(e_s));
         chk("r", 32'(r), 32'(e_r));
         chk("s_and_r", 32'(s && r), 32'(0));
         chk("level", 32'(level), 32'(sz));
         chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("mismatch", 32'(mismatch), 32'(e_mm));
         if (cyc == check_cyc) chk("q_at_check", 32'(q), 32'(model_q));
      end
      if (rst) begin
         mq.delete();
         free_cyc  = cyc + 1;
         pulse_cyc = -1;
         check_cyc = -1;
         mm_cyc    = -1;
         armed     = 1'b1;
      end else begin
         if (cyc == check_cyc) begin
            mm_cyc = cyc + 1;
            mm_val = (q_fb != check_exp);
         end
         if (cyc >= free_cyc && sz != 0) begin
            op = mq.pop_front();
            pulse_s = 1'b0;
            pulse_r = 1'b0;
            case (op)
               SR_OP_SET: begin pulse_s = 1'b1; check_exp = 1'b1; model_q = 1'b1; end
               SR_OP_CLR: begin pulse_r = 1'b1; check_exp = 1'b0; model_q = 1'b0; end
               SR_OP_TGL: begin
                  pulse_s = !q_fb; pulse_r = q_fb; check_exp = !q_fb; model_q = !model_q;
               end
               default: check_exp = q_fb;
            endcase
            pulse_cyc = cyc + 1;
            check_cyc = cyc + 2;
            free_cyc  = cyc + 3 + GAP_P;
         end
         if (cmd_valid && e_rdy) mq.push_back(cmd_op);
      end
   end

   always @(negedge clk) begin
      if (s || r) begin
         pcyc.push_back(cyc);
         pcode.push_back({s, r});
      end
      if (mismatch) mm_cnt++;
      if (int'(level) > max_level) max_level = int'(level);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input sr_op_t op);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      while (!cmd_ready && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL push_timeout: cmd_ready stayed %0b, expected 1", cmd_ready);
      end
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sr_op_t seq3[10];
      int     n;
      logic   acc;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_s", 32'(s), 32'(0));
      chk("rst_r", 32'(r), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_mismatch", 32'(mismatch), 32'(0));
      chk("rst_ready_in_rst", 32'(cmd_ready), 32'(0));
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(cmd_ready), 32'(1));

      // Single set from empty
      push_op(SR_OP_SET);
      cmd_valid = 1'b0;
      chk("t1_level_e1", 32'(level), 32'(1));
      chk("t1_s_e1", 32'(s), 32'(0));
      tick();
      chk("t1_s_e2", 32'(s), 32'(1));
      chk("t1_r_e2", 32'(r), 32'(0));
      tick();
      chk("t1_s_e3", 32'(s), 32'(0));
      chk("t1_q_e3", 32'(q), 32'(1));
      tick();
      chk("t1_mismatch_e4", 32'(mismatch), 32'(0));
      chk("t1_busy_gap", 32'(busy), 32'(1));
      tick();
      chk("t1_busy_after_gap", 32'(busy), 32'(0));

      // Back-to-back set, toggle, toggle, hold, clear
      pcyc.delete();
      pcode.delete();
      mm_cnt = 0;
      push_op(SR_OP_SET);
      push_op(SR_OP_TGL);
      push_op(SR_OP_TGL);
      push_op(SR_OP_HOLD);
      push_op(SR_OP_CLR);
      cmd_valid = 1'b0;
      chk("t2_level_full", 32'(level), 32'(4));
      chk("t2_ready_full", 32'(cmd_ready), 32'(0));
      for (int i = 0; i < 20; i++) tick();
      chk("t2_pulse_count", 32'(pcode.size()), 32'(4));
      if (pcode.size() == 4) begin
         chk("t2_pulse0", 32'(pcode[0]), 32'(2'b10));
         chk("t2_pulse1", 32'(pcode[1]), 32'(2'b01));
         chk("t2_pulse2", 32'(pcode[2]), 32'(2'b10));
         chk("t2_pulse3", 32'(pcode[3]), 32'(2'b01));
         chk("t2_gap01", 32'(pcyc[1] - pcyc[0]), 32'(4));
         chk("t2_gap12", 32'(pcyc[2] - pcyc[1]), 32'(4));
         chk("t2_gap23", 32'(pcyc[3] - pcyc[2]), 32'(8));
      end
      chk("t2_q_final", 32'(q), 32'(0));
      chk("t2_no_mismatch", 32'(mm_cnt), 32'(0));
      wait_idle();

      // Fill to DEPTH while issuing, across pointer wrap
      seq3 = '{SR_OP_SET, SR_OP_CLR, SR_OP_SET, SR_OP_CLR, SR_OP_TGL,
               SR_OP_HOLD, SR_OP_TGL, SR_OP_SET, SR_OP_CLR, SR_OP_TGL};
      max_level = 0;
      foreach (seq3[i]) push_op(seq3[i]);
      cmd_valid = 1'b0;
      wait_idle();
      chk("t3_max_level", 32'(max_level), 32'(4));
      chk("t3_q_final", 32'(q), 32'(1));

      // Forced feedback mismatch
      push_op(SR_OP_SET);
      cmd_valid = 1'b0;
      tick();
      tick();
      force_low = 1'b1;
      chk("t4_mm_in_check", 32'(mismatch), 32'(0));
      tick();
      force_low = 1'b0;
      chk("t4_mm_pulse", 32'(mismatch), 32'(1));
      tick();
      chk("t4_mm_one_cycle", 32'(mismatch), 32'(0));
      wait_idle();

      // Reset during ISSUE with three queued commands
      for (int i = 0; i < 5; i++) push_op(SR_OP_SET);
      cmd_valid = 1'b0;
      n = 0;
      while (!(s || r) && n < 10) begin
         tick();
         n++;
      end
      chk("t5_in_issue", 32'(s), 32'(1));
      chk("t5_queued", 32'(level), 32'(3));
      rst = 1'b1;
      tick();
      chk("t5_s_after_rst", 32'(s), 32'(0));
      chk("t5_r_after_rst", 32'(r), 32'(0));
      chk("t5_level_after_rst", 32'(level), 32'(0));
      rst = 1'b0;
      #1;
      chk("t5_ready_after_rst", 32'(cmd_ready), 32'(1));
      pcyc.delete();
      pcode.delete();
      mm_cnt = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("t5_no_pulses", 32'(pcode.size()), 32'(0));
      chk("t5_no_mismatch", 32'(mm_cnt), 32'(0));
      chk("t5_busy", 32'(busy), 32'(0));

      // Random op stream
      for (int i = 0; i < 10000; i++) begin
         if (!cmd_valid && $urandom_range(0, 2) != 0) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
         end
         acc = cmd_valid && cmd_ready;
         tick();
         if (acc) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
